// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - fetch/data arbiter for a shared unified memory port
module unified_mem_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_req_i,
    input  logic [31:0] i_addr_i,
    output logic [31:0] i_rdata_o,
    output logic        i_ready_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic [31:0] d_rdata_o,
    output logic        d_ready_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        stall_if_o,
    output logic        stall_mem_o
);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] streak;
    logic       i_elig;
    logic       d_elig;
    logic       grant_i;
    logic       grant_d;
    logic       ack_hit;

    // A port whose ready pulses this cycle is dropping its request; never serve it twice.
    assign i_elig      = i_req_i & ~i_ready_o;
    assign d_elig      = d_req_i & ~d_ready_o;
    assign stall_if_o  = i_req_i & ~i_ready_o;
    assign stall_mem_o = d_req_i & ~d_ready_o;
    assign ack_hit     = (state != IDLE) && mem_ack_i;

    // Next state and grant decision: data wins until its streak reaches the starvation limit.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (d_elig && (!i_elig || (streak < STARVE_LIM))) begin
                    grant_d   = 1'b1;
                    state_nxt = D_BUSY;
                end else if (i_elig) begin
                    grant_i   = 1'b1;
                    state_nxt = I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (mem_ack_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Consecutive data grants made while fetch was waiting, saturating at the limit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            streak <= 4'd0;
        end else if (grant_i) begin
            streak <= 4'd0;
        end else if (grant_d) begin
            if (!i_req_i) begin
                streak <= 4'd0;
            end else if (streak < STARVE_LIM) begin
                streak <= streak + 4'd1;
            end
        end
    end

    // Memory-side request registers, ready pulses and read-data capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'd0;
            mem_wdata_o <= 32'd0;
            i_ready_o   <= 1'b0;
            d_ready_o   <= 1'b0;
            i_rdata_o   <= 32'd0;
            d_rdata_o   <= 32'd0;
        end else begin
            i_ready_o <= 1'b0;
            d_ready_o <= 1'b0;
            if (grant_d) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= d_we_i;
                mem_addr_o  <= d_addr_i;
                mem_wdata_o <= d_wdata_i;
            end else if (grant_i) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= 1'b0;
                mem_addr_o  <= i_addr_i;
                mem_wdata_o <= 32'd0;
            end else if (ack_hit) begin
                mem_req_o <= 1'b0;
                mem_we_o  <= 1'b0;
                if (state == I_BUSY) begin
                    i_ready_o <= 1'b1;
                    i_rdata_o <= mem_rdata_i;
                end else begin
                    d_ready_o <= 1'b1;
                    if (!mem_we_o) begin
                        d_rdata_o <= mem_rdata_i;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - randomized bench for unified_mem_arbiter against a transaction-level model
module tb_unified_mem_arbiter;

    localparam int SMAX = 3;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        i_req_i;
    logic [31:0] i_addr_i;
    logic [31:0] i_rdata_o;
    logic        i_ready_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        d_ready_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        stall_if_o;
    logic        stall_mem_o;

    unified_mem_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_rdata_o(i_rdata_o), .i_ready_o(i_ready_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who owns the memory (none/fetch/data), the outstanding
    // transaction record, and how many data grants fetch has watched go by.
    typedef enum int {NONE, FETCH, DATA} owner_t;
    owner_t      owner;
    int          data_run;
    logic        e_req, e_we, e_iready, e_dready;
    logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;
    int          fetch_wait;

    // Stimulus knobs in percent; reset in per-mille.
    int p_i, p_d, p_ack, p_spur, p_rst;

    task automatic model_reset();
        owner = NONE; data_run = 0; fetch_wait = 0;
        e_req = 0; e_we = 0; e_iready = 0; e_dready = 0;
        e_addr = 0; e_wdata = 0; e_irdata = 0; e_drdata = 0;
    endtask

    task automatic check_regs();
        check("mem_req",   {31'd0, mem_req_o}, {31'd0, e_req});
        check("mem_we",    {31'd0, mem_we_o},  {31'd0, e_we});
        check("mem_addr",  mem_addr_o,  e_addr);
        check("mem_wdata", mem_wdata_o, e_wdata);
        check("i_ready",   {31'd0, i_ready_o}, {31'd0, e_iready});
        check("d_ready",   {31'd0, d_ready_o}, {31'd0, e_dready});
        check("i_rdata",   i_rdata_o, e_irdata);
        check("d_rdata",   d_rdata_o, e_drdata);
    endtask

    task automatic cycle();
        bit ie, de;
        @(negedge clk_i);
        check_regs();
        rst_i = ($urandom_range(999) < p_rst);
        // Requesters hold a pending request; after completion (or idle) they may issue a new one.
        if (!(i_req_i && !e_iready)) begin
            i_req_i = ($urandom_range(99) < p_i);
            if ($urandom_range(1) == 1) i_addr_i = $urandom;
        end
        if (!(d_req_i && !e_dready)) begin
            d_req_i = ($urandom_range(99) < p_d);
            if ($urandom_range(1) == 1) begin
                d_addr_i = $urandom; d_we_i = $urandom_range(1); d_wdata_i = $urandom;
            end
        end
        mem_rdata_i = $urandom;
        mem_ack_i = e_req ? ($urandom_range(99) < p_ack) : ($urandom_range(99) < p_spur);
        #1;
        check("stall_if",  {31'd0, stall_if_o},  {31'd0, i_req_i & ~e_iready});
        check("stall_mem", {31'd0, stall_mem_o}, {31'd0, d_req_i & ~d_ready_o & ~e_dready | d_req_i & ~e_dready});
        // Advance the model by one clock edge.
        if (rst_i) begin
            model_reset();
        end else begin
            e_iready = 0; e_dready = 0;
            ie = i_req_i && !i_ready_o_model();
            de = d_req_i && !d_ready_o_model();
            if (owner != NONE) begin
                if (mem_ack_i) begin
                    if (owner == FETCH) begin
                        e_iready = 1; e_irdata = mem_rdata_i;
                    end else begin
                        e_dready = 1;
                        if (!e_we) e_drdata = mem_rdata_i;
                    end
                    e_req = 0; e_we = 0; owner = NONE;
                end
            end else if (de && (!ie || data_run < SMAX)) begin
                owner = DATA; e_req = 1; e_we = d_we_i; e_addr = d_addr_i; e_wdata = d_wdata_i;
                data_run = i_req_i ? ((data_run + 1 > SMAX) ? SMAX : data_run + 1) : 0;
                if (ie) fetch_wait++;
            end else if (ie) begin
                owner = FETCH; e_req = 1; e_we = 0; e_addr = i_addr_i; e_wdata = 0;
                data_run = 0;
                check("fetch_starve_bound", {31'd0, fetch_wait > SMAX}, 32'd0);
                fetch_wait = 0;
            end
        end
    endtask

    // Ready values the DUT is presenting this cycle, as predicted by the model
    // before it advances (captured at negedge, unchanged until the edge).
    logic pre_iready, pre_dready;
    function automatic logic i_ready_o_model(); return pre_iready; endfunction
    function automatic logic d_ready_o_model(); return pre_dready; endfunction
    always @(negedge clk_i) begin
        pre_iready = e_iready;
        pre_dready = e_dready;
    end

    task automatic phase(input int n, input int pi, input int pd, input int pa, input int ps, input int pr);
        p_i = pi; p_d = pd; p_ack = pa; p_spur = ps; p_rst = pr;
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        rst_i = 1; i_req_i = 0; d_req_i = 0; d_we_i = 0;
        i_addr_i = 0; d_addr_i = 0; d_wdata_i = 0; mem_rdata_i = 0; mem_ack_i = 0;
        model_reset();
        pre_iready = 0; pre_dready = 0;
        @(posedge clk_i);
        @(posedge clk_i);
        rst_i = 0;
        // Reset state, then zero-wait saturation (D,D,D,I pattern), random mix,
        // slow memory with resets, and spurious acks while idle.
        phase(4,    0,   0,   100, 0,  0);
        phase(80,   100, 100, 100, 0,  0);
        phase(1500, 60,  60,  50,  20, 5);
        phase(800,  90,  90,  25,  30, 20);
        phase(60,   0,   0,   0,   50, 0);
        phase(300,  40,  70,  100, 10, 2);
        @(negedge clk_i);
        check_regs();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares a single unified memory port between the pipeline's instruction-fetch requester (IF stage, PC/IFID side) and its data requester (MEM stage, EXMEM side). It runs a small FSM with a req/ack handshake toward memory and a one-cycle ready pulse toward each requester. It drives stall outputs that freeze PC/IFID and the pipeline registers while a requester waits. A bounded-starvation rule gives data priority without locking out fetch.

## Interface
- STARVE_MAX, 3: max consecutive data grants while a fetch is pending; next grant then goes to fetch (range 1–15)
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset; synchronous, active-high
- i_req_i  in  1  fetch request; held high until i_ready_o
- i_addr_i  in  32  fetch address; stable while i_req_i
- i_rdata_o  out  32  fetched instruction; valid when i_ready_o, held until next fetch completes
- i_ready_o  out  1  one-cycle completion pulse for fetch
- d_req_i  in  1  data request; held high until d_ready_o
- d_we_i  in  1  1 = store, 0 = load; stable while d_req_i
- d_addr_i  in  32  data address
- d_wdata_i  in  32  store data
- d_rdata_o  out  32  load data; valid when d_ready_o after a load, held otherwise
- d_ready_o  out  1  one-cycle completion pulse for data
- mem_req_o  out  1  memory request; high until mem_ack_i
- mem_we_o  out  1  write enable to memory
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data; valid with mem_ack_i
- mem_ack_i  in  1  memory completion; sampled only while mem_req_o=1
- stall_if_o  out  1  i_req_i & ~i_ready_o (combinational)
- stall_mem_o  out  1  d_req_i & ~d_ready_o (combinational)

## Operation
- States: IDLE, I_BUSY, D_BUSY.
- In IDLE with no eligible request: stay in IDLE.
- A request is eligible in IDLE unless that port's ready is high this cycle. The requester is dropping it, so this prevents double service.
- Arbitration in IDLE when both requests are eligible:
  - Grant data if streak < STARVE_MAX.
  - Otherwise grant fetch.
- With only one eligible request, grant it.
- On grant, at the edge:
  - Register the address, we, and wdata of the granted port into the mem_* outputs (fetch: mem_we_o=0, mem_wdata_o=0).
  - Set mem_req_o=1.
  - Enter I_BUSY or D_BUSY.
- In *_BUSY:
  - Hold mem_* stable.
  - On mem_ack_i=1, at the edge:
    - Clear mem_req_o and mem_we_o.
    - Pulse the matching ready for exactly one cycle.
    - Capture mem_rdata_i into i_rdata_o (fetch) or d_rdata_o (load only; a store leaves d_rdata_o unchanged).
    - Return to IDLE.
- Streak counter, 4 bits, saturating at STARVE_MAX:
  - +1 on a data grant made while i_req_i=1.
  - Cleared on a fetch grant.
  - Cleared on a data grant made while i_req_i=0.
- mem_ack_i while in IDLE: ignored, no state or output change.
- The arbiter never reorders or splits a transaction. At most one transaction is outstanding.

## Timing
- Reset values (state after an edge with rst_i=1):
  - state=IDLE, streak=0.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - i_ready_o=0, d_ready_o=0, i_rdata_o=0, d_rdata_o=0.
- Reset mid-transaction: the outstanding access is abandoned and mem_req_o=0 after the reset edge. A late mem_ack_i is ignored.
- Latency: request high in cycle 0 while IDLE, mem_req_o high from cycle 1.
  - Ack in cycle k≥1 gives ready in cycle k+1.
  - Minimum request-to-ready is 2 cycles (ack in cycle 1).
- In the cycle a ready pulses, the state is IDLE, so the other port can be granted in that same cycle. Alternating fetch/data gives one grant every 2 cycles with zero-wait memory.
- Stall outputs are combinational on registered ready, with no added latency. With no request pending, stalls are 0.
- Memory contract: mem_ack_i may be asserted in the first cycle mem_req_o is high. The arbiter holds mem_* unchanged until ack.

## Test plan
- Single fetch, zero-wait memory: i_req_i=1, i_addr_i=0x40, ack in the first cycle with rdata=0x8C220004 -> mem_req_o high in cycle 1, i_ready_o in cycle 2, i_rdata_o=0x8C220004, stall_if_o=1 in cycles 0–1 and 0 in cycle 2.
- Store then load, 2-wait memory: store 0xDEADBEEF to 0x10, then load 0x10 with mem_rdata_i=0xDEADBEEF -> mem_we_o=1 only during the store, d_rdata_o unchanged at the store's d_ready_o, d_rdata_o=0xDEADBEEF at the load's d_ready_o, and each d_ready_o 3 cycles after its grant edge.
- Simultaneous requests, STARVE_MAX=3, data re-requested every cycle it is eligible and fetch held high -> grant order D,D,D,I,D,D,D,I; i_ready_o never more than 4 data transactions late.
- Collision at the ready cycle: d_ready_o pulses while i_req_i=1 and d_req_i is still high that cycle -> fetch granted that cycle, data not re-served, mem_addr_o=fetch address at the next edge.
- Reset during D_BUSY with ack withheld, then ack pulsed after reset -> all outputs at reset values, state IDLE, no ready pulse, no rdata change.
- Spurious mem_ack_i while IDLE with no requests -> no ready pulses, rdata outputs unchanged, mem_req_o stays 0.
